seq_detect_fsm: RTL and testbench
=================================

SEQ_DETECT_FSM -- requirements
Module: seq_detect_fsm

Interface
REQ-001 Parameter M, default 6, SHALL set the pattern length in bits.
REQ-002 Parameter CW, default 8, SHALL set the match-counter width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 din  input  1  SHALL be the serial bit stream, MSB of the pattern first, as emitted by the upstream shift-register sequence generator.
REQ-006 din_valid  input  1  SHALL qualify din; din is sampled only on edges where din_valid=1.
REQ-007 load  input  1  SHALL load a new reference pattern from pat.
REQ-008 pat  input  M  SHALL carry the new pattern; pat[M-1] is the first-received bit.
REQ-009 match  output  1  SHALL be a registered one-cycle pulse on pattern detection.
REQ-010 match_cnt  output  CW  SHALL be a registered, saturating count of detections.
REQ-011 filling  output  1  SHALL be high while the FSM is in state FILL.

Function
REQ-012 Internal state: pattern register pat_r[M-1:0], window win[M-1:0], fill counter fill_cnt (0..M), FSM {FILL, RUN}.
REQ-013 Sampled bit: win <= {win[M-2:0], din}, so the oldest bit sits in win[M-1].
REQ-014 FILL: each sampled bit increments fill_cnt; when the increment reaches M, the FSM moves to RUN on that same edge.
REQ-015 RUN: fill_cnt holds at M.
REQ-016 Detection: on a sampling edge where the post-shift window equals pat_r and the post-increment fill_cnt equals M, match SHALL be 1 for the following cycle only.
REQ-017 Latency: match asserts exactly 1 clk after the edge that samples the completing bit.
REQ-018 match SHALL be 0 in every cycle not covered by REQ-016, including all cycles with din_valid=0.
REQ-019 Each match SHALL increment match_cnt; match_cnt SHALL hold at 2^CW-1 and never wrap.
REQ-020 load=1 at an edge SHALL:
  - set pat_r <= pat, win <= 0, fill_cnt <= 0, match_cnt <= 0, match <= 0;
  - move the FSM to FILL;
  - ignore din on that edge, even if din_valid=1 (load has priority).
REQ-021 load arriving mid-pattern SHALL discard the partial window; no match may use bits sampled before the load.
REQ-022 din_valid=0 gaps of any length SHALL freeze win, fill_cnt and the FSM.

Reset
REQ-023 While rst_n=0, all registers SHALL take these values immediately, independent of clk:
  - pat_r = 100111 (M=6; for other M, the low M bits of that value zero-extended);
  - win = 0, fill_cnt = 0, FSM = FILL;
  - match = 0, match_cnt = 0, filling = 1.
REQ-024 Reset deassertion SHALL take effect on the next rising clk edge; no match SHALL occur before M bits have been sampled after reset.

Configuration
REQ-025 Macro SEQ_DET_NO_OVERLAP_EN SHALL select the detection mode.
  - Defined: on each match the FSM SHALL return to FILL with fill_cnt=0 and win=0, so the next detection needs M fresh bits.
  - Undefined (default): the FSM stays in RUN after a match and overlapping occurrences are detected.

Verification
REQ-026 Reset, pat default, 18 valid bits of 100111 repeated -> match pulses after bits 6, 12 and 18; match_cnt=3 (both modes).
REQ-027 Stream 1,0,0,1,1,1,0,0,1,1,1 -> overlap mode: match after bits 6 and 11, match_cnt=2; SEQ_DET_NO_OVERLAP_EN: single match after bit 6, match_cnt=1.
REQ-028 Send 1,0,0 then load with pat=101010, then bits 1,0,1,0,1,0 -> exactly one match after the 6th post-load bit, and none before it.
REQ-029 Stream 1,0,0 / din_valid=0 for 5 cycles / 1,1,1 -> one match, 1 clk after the final 1; match=0 throughout the gap.
REQ-030 CW=2, 5 back-to-back pattern repeats -> match_cnt saturates at 3 and stays at 3.
REQ-031 Assert rst_n=0 asynchronously mid-stream after 4 bits -> outputs take reset values before the next edge; after release, 5 further pattern bits produce no match.

Source files
------------

// File: rtl/seq_detect_fsm.sv
// Serial pattern detector: compares the last M sampled bits of din against a loadable reference.
// Define SEQ_DET_NO_OVERLAP_EN to restart filling after every match (non-overlapping detection).
module seq_detect_fsm #(
  parameter int unsigned M  = 6,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_valid,
  input  logic          load,
  input  logic [M-1:0]  pat,
  output logic          match,
  output logic [CW-1:0] match_cnt,
  output logic          filling
);

  localparam int unsigned    FW        = $clog2(M + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(M);
  localparam logic [M-1:0]   PAT_RST   = M'(32'b100111);
  localparam logic [CW-1:0]  CNT_MAX   = '1;

  typedef enum logic {
    FILL,
    RUN
  } state_t;

  state_t        state;
  logic [M-1:0]  pat_r;
  logic [M-1:0]  win;
  logic [FW-1:0] fill_cnt;

  logic [M-1:0]  win_nx;
  logic [FW-1:0] fill_nx;
  logic          hit;

  // Detection looks at the post-shift window so the match is seen on the completing edge.
  always_comb begin
    win_nx  = {win[M-2:0], din};
    fill_nx = (state == FILL) ? fill_cnt + FW'(1) : FILL_FULL;
    hit     = (win_nx == pat_r) && (fill_nx == FILL_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      pat_r     <= PAT_RST;
      win       <= '0;
      fill_cnt  <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (load) begin
      state     <= FILL;
      pat_r     <= pat;
      win       <= '0;
      fill_cnt  <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
    end else if (din_valid) begin
      win      <= win_nx;
      fill_cnt <= fill_nx;
      match    <= hit;
      if (hit && (match_cnt != CNT_MAX))
        match_cnt <= match_cnt + CW'(1);
      if (fill_nx == FILL_FULL)
        state <= RUN;
`ifdef SEQ_DET_NO_OVERLAP_EN
      if (hit) begin
        state    <= FILL;
        fill_cnt <= '0;
        win      <= '0;
      end
`endif
    end else begin
      match <= 1'b0;
    end
  end

  assign filling = (state == FILL);

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed + randomized bench for seq_detect_fsm; a queue-based model of the last M sampled
// bits predicts match/match_cnt/filling for a CW=8 and a CW=2 instance driven in parallel.
module tb_seq_detect_fsm;

  localparam int unsigned M = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         load = 1'b0;
  logic [M-1:0] pat = '0;
  logic         match, match2, filling, filling2;
  logic [7:0]   match_cnt;
  logic [1:0]   match_cnt2;

  always #5 clk = ~clk;

  seq_detect_fsm #(.M(M), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
    .pat(pat), .match(match), .match_cnt(match_cnt), .filling(filling)
  );

  seq_detect_fsm #(.M(M), .CW(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .load(load),
    .pat(pat), .match(match2), .match_cnt(match_cnt2), .filling(filling2)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: recent sampled bits since the last load/reset (or last match when
  // detection is non-overlapping), capped at M, compared bit-by-bit with the pattern.
  bit           q[$];
  logic [M-1:0] m_pat;
  int unsigned  m_cnt;
  bit           m_match;

  function automatic bit window_hits();
    if (q.size() != M) return 1'b0;
    for (int unsigned i = 0; i < M; i++)
      if (q[i] != m_pat[M-1-i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pat   = 6'b100111;
    m_cnt   = 0;
    m_match = 1'b0;
  endfunction

  function automatic void model_edge(input bit v, input bit d, input bit ld, input logic [M-1:0] p);
    if (ld) begin
      q.delete();
      m_pat   = p;
      m_cnt   = 0;
      m_match = 1'b0;
    end else if (v) begin
      q.push_back(d);
      if (q.size() > M) void'(q.pop_front());
      m_match = window_hits();
      if (m_match) begin
        m_cnt++;
`ifdef SEQ_DET_NO_OVERLAP_EN
        q.delete();
`endif
      end
    end else begin
      m_match = 1'b0;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int unsigned sat8, sat2;
    sat8 = (m_cnt > 255) ? 255 : m_cnt;
    sat2 = (m_cnt > 3) ? 3 : m_cnt;
    chk({tag, ".match"},     {31'd0, match},      {31'd0, m_match});
    chk({tag, ".match_cnt"}, {24'd0, match_cnt},  sat8);
    chk({tag, ".filling"},   {31'd0, filling},    {31'd0, (q.size() < M)});
    chk({tag, ".match2"},    {31'd0, match2},     {31'd0, m_match});
    chk({tag, ".cnt2"},      {30'd0, match_cnt2}, sat2);
    chk({tag, ".filling2"},  {31'd0, filling2},   {31'd0, (q.size() < M)});
  endtask

  task automatic step(input string tag, input bit v, input bit d,
                      input bit ld = 1'b0, input logic [M-1:0] p = '0);
    din = d; din_valid = v; load = ld; pat = p;
    @(posedge clk);
    model_edge(v, d, ld, p);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must settle before any clock edge.
  task automatic async_reset(input string tag);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk({tag, ".rst_match"},   {31'd0, match},     32'd0);
    chk({tag, ".rst_cnt"},     {24'd0, match_cnt}, 32'd0);
    chk({tag, ".rst_filling"}, {31'd0, filling},   32'd1);
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_bits(input string tag, input logic [31:0] bits, input int unsigned n);
    for (int i = int'(n) - 1; i >= 0; i--)
      step(tag, 1'b1, bits[i]);
  endtask

  initial begin
    logic [M-1:0] dflt;
    logic [M-1:0] alt;
    int unsigned  ptr;
    dflt = 6'b100111;
    alt  = 6'b101010;

    // Power-on reset, before the first clock edge
    #1;
    model_reset();
    chk("por.match",   {31'd0, match},     32'd0);
    chk("por.cnt",     {24'd0, match_cnt}, 32'd0);
    chk("por.filling", {31'd0, filling},   32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Default pattern repeated three times: matches after bits 6, 12, 18
    for (int r = 0; r < 3; r++) send_bits("rep3", {26'd0, dflt}, M);
    chk("rep3.total", {24'd0, match_cnt}, 32'd3);

    // Overlapping occurrence
    async_reset("ovl");
    send_bits("ovl", 32'b10011100111, 11);
`ifdef SEQ_DET_NO_OVERLAP_EN
    chk("ovl.total", {24'd0, match_cnt}, 32'd1);
`else
    chk("ovl.total", {24'd0, match_cnt}, 32'd2);
`endif

    // Load mid-pattern with din_valid=1 on the load edge; partial window discarded
    async_reset("ld");
    send_bits("ld.pre", 32'b100, 3);
    step("ld.edge", 1'b1, 1'b1, 1'b1, alt);
    send_bits("ld.post", {26'd0, alt}, M);
    chk("ld.total", {24'd0, match_cnt}, 32'd1);

    // din_valid gap freezes the window
    async_reset("gap");
    send_bits("gap.a", 32'b100, 3);
    for (int g = 0; g < 5; g++) step("gap.idle", 1'b0, 1'($urandom_range(0, 1)));
    send_bits("gap.b", 32'b111, 3);
    step("gap.after", 1'b0, 1'b0);

    // Five back-to-back repeats: CW=2 instance saturates at 3
    async_reset("sat");
    for (int r = 0; r < 5; r++) send_bits("sat", {26'd0, dflt}, M);
    chk("sat.cnt2", {30'd0, match_cnt2}, 32'd3);
    step("sat.hold", 1'b0, 1'b0);

    // Async reset after a match and 4 more bits; 5 pattern bits afterwards give no match
    async_reset("ar");
    send_bits("ar.a", {26'd0, dflt}, M);
    send_bits("ar.b", 32'b1001, 4);
    async_reset("ar.mid");
    send_bits("ar.c", 32'b11100, 5);
    chk("ar.total", {24'd0, match_cnt}, 32'd0);

    // Randomized stream, biased toward the current pattern to produce matches
    ptr = 0;
    for (int k = 0; k < 600; k++) begin
      bit           v, d, ld;
      logic [M-1:0] p;
      ld = ($urandom_range(0, 60) == 0);
      p  = ($urandom_range(0, 1) == 0) ? dflt : M'($urandom);
      v  = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) != 0) d = m_pat[M-1-ptr];
      else d = 1'($urandom_range(0, 1));
      if (v && !ld) ptr = (ptr + 1) % M;
      if (ld) ptr = 0;
      step("rnd", v, d, ld, p);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
